// File: rtl/seq_pkg.sv
// Shared definitions for the sync-word detector and its downstream payload capture.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } cap_state_e;

  localparam logic [11:0] SYNC_WORD = 12'b1110_1101_1011;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/sync_payload_capture.sv
// Deserializes PAYLOAD_W bits after each detect pulse and offers them on valid/ready.
// Optional trailing even-parity bit: define SYNC_PAYLOAD_PARITY_EN.
module sync_payload_capture
  import seq_pkg::*;
#(
  parameter int unsigned PAYLOAD_W  = 8,
  parameter int unsigned DROP_CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  x_i,
  input  logic                  det_i,
  output logic [PAYLOAD_W-1:0]  payload_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o,
  output logic                  parity_err_o
);

  localparam int unsigned CNT_W = $clog2(PAYLOAD_W + 2);
`ifdef SYNC_PAYLOAD_PARITY_EN
  localparam int unsigned TOT_BITS = PAYLOAD_W + 1;
`else
  localparam int unsigned TOT_BITS = PAYLOAD_W;
`endif

  cap_state_e           r_state, w_state_nxt;
  logic [PAYLOAD_W-1:0] r_shift;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic                 r_valid, r_busy;
  logic                 w_shift_en, w_drop_inc, w_last;

  assign w_last = (r_cnt == CNT_W'(TOT_BITS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_en  = 1'b0;
    w_drop_inc  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (det_i) begin
          w_shift_en  = 1'b1;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        // det_i deliberately ignored: sync patterns inside the payload are data.
        w_shift_en = 1'b1;
        w_cnt_nxt  = r_cnt + 1'b1;
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = HOLD;
`ifdef SYNC_PAYLOAD_PARITY_EN
          w_shift_en  = 1'b0;
`endif
        end
      end
      HOLD: begin
        if (ready_i) begin
          if (det_i) begin
            w_shift_en  = 1'b1;
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = CAPTURE;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (det_i) begin
          w_drop_inc = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      if (w_shift_en) r_shift <= {r_shift[PAYLOAD_W-2:0], x_i};
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_state_nxt == HOLD);
      r_busy  <= (w_state_nxt == CAPTURE);
    end
  end

`ifdef SYNC_PAYLOAD_PARITY_EN
  logic r_perr;

  // The trailing bit on x_i is the parity bit itself; it never enters r_shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          r_perr <= 1'b0;
    else if ((r_state == CAPTURE) && w_last) r_perr <= (^r_shift) ^ x_i;
  end

  assign parity_err_o = r_perr;
`else
  assign parity_err_o = 1'b0;
`endif

  sat_counter #(
    .W(DROP_CNT_W)
  ) u_drop_cnt (
    .i_clk  (clk),
    .i_rst_n(reset_n),
    .i_inc  (w_drop_inc),
    .i_clr  (1'b0),
    .o_cnt  (drop_cnt_o)
  );

  assign payload_o = r_shift;
  assign valid_o   = r_valid;
  assign busy_o    = r_busy;

endmodule

// File: tb/tb_sync_payload_capture.sv
// Directed bench for sync_payload_capture: frame table plus back-to-back and reset sequences.
module tb_sync_payload_capture;
  import seq_pkg::*;

  localparam int PW = 8;
`ifdef SYNC_PAYLOAD_PARITY_EN
  localparam int TOT = PW + 1;
`else
  localparam int TOT = PW;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          x_i = 1'b0;
  logic          det_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [PW-1:0] payload_o;
  logic          valid_o;
  logic          busy_o;
  logic [3:0]    drop_cnt_o;
  logic          parity_err_o;

  int n_vec = 0;
  int n_err = 0;

  sync_payload_capture #(
    .PAYLOAD_W (PW),
    .DROP_CNT_W(4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .x_i         (x_i),
    .det_i       (det_i),
    .payload_o   (payload_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .drop_cnt_o  (drop_cnt_o),
    .parity_err_o(parity_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pl;
    logic       par;
    int         stall;
    int         drops;
    int         exp_drop;
    logic       exp_perr_par;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic x, input logic det, input logic rdy);
    x_i = x;
    det_i = det;
    ready_i = rdy;
  endtask

  task automatic capture_bits(input logic [7:0] pl, input logic par, input logic rdy,
                              output int lat, output logic busy_ok);
    busy_ok = 1'b1;
    drive(pl[7], 1'b1, rdy);
    lat = 0;
    for (int k = 1; k < TOT; k++) begin
      tick();
      lat++;
      if (!busy_o || valid_o) busy_ok = 1'b0;
      if (k < PW) drive(pl[7-k], 1'b0, rdy);
      else        drive(par, 1'b0, rdy);
    end
    do begin
      tick();
      lat++;
      if (valid_o) break;
      drive(1'b0, 1'b0, rdy);
    end while (lat < 40);
  endtask

  task automatic send_sync(input logic rdy);
    logic [11:0] sw;
    sw = SYNC_WORD;
    for (int i = 0; i < 12; i++) begin
      drive(sw[11-i], 1'b0, rdy);
      tick();
    end
  endtask

  function automatic logic exp_perr(input logic p);
`ifdef SYNC_PAYLOAD_PARITY_EN
    return p;
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic bok;
    int   bad;
    logic det;

    tbl[0] = '{8'hA5, 1'b0, 0,  0,  0,  1'b0};
    tbl[1] = '{8'h3C, 1'b1, 20, 0,  0,  1'b1};
    tbl[2] = '{8'h5A, 1'b0, 6,  3,  3,  1'b0};
    tbl[3] = '{8'hFF, 1'b0, 2,  0,  3,  1'b0};
    tbl[4] = '{8'h81, 1'b1, 30, 14, 15, 1'b1};
    tbl[5] = '{8'h01, 1'b0, 0,  0,  15, 1'b1};
    tbl[6] = '{8'h01, 1'b1, 0,  0,  15, 1'b0};

    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("reset payload", 32'(payload_o), 32'h0);
    chk("reset valid", 32'(valid_o), 32'h0);
    chk("reset busy", 32'(busy_o), 32'h0);
    chk("reset drop", 32'(drop_cnt_o), 32'h0);
    chk("reset perr", 32'(parity_err_o), 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      send_sync(tbl[i].stall == 0);
      capture_bits(tbl[i].pl, tbl[i].par, tbl[i].stall == 0, lat, bok);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(TOT));
      chk($sformatf("v%0d busy during capture", i), 32'(bok), 32'h1);
      chk($sformatf("v%0d valid", i), 32'(valid_o), 32'h1);
      chk($sformatf("v%0d payload", i), 32'(payload_o), 32'(tbl[i].pl));
      chk($sformatf("v%0d perr", i), 32'(parity_err_o), 32'(exp_perr(tbl[i].exp_perr_par)));
      bad = 0;
      for (int s = 0; s < tbl[i].stall; s++) begin
        det = (s < 2 * tbl[i].drops) && (s % 2 == 0);
        drive(1'($urandom), det, 1'b0);
        tick();
        if (!valid_o || payload_o !== tbl[i].pl) bad++;
      end
      if (tbl[i].stall > 0) chk($sformatf("v%0d held cycles bad", i), 32'(bad), 32'h0);
      chk($sformatf("v%0d drop_cnt", i), 32'(drop_cnt_o), 32'(tbl[i].exp_drop));
      drive(1'b0, 1'b0, 1'b1);
      tick();
      chk($sformatf("v%0d valid after transfer", i), 32'(valid_o), 32'h0);
      chk($sformatf("v%0d busy after transfer", i), 32'(busy_o), 32'h0);
    end

    // Back-to-back: det_i and ready_i together in HOLD.
    send_sync(1'b0);
    capture_bits(8'h96, 1'b0, 1'b0, lat, bok);
    chk("b2b first payload", 32'(payload_o), 32'h96);
    capture_bits(8'h0F, 1'b0, 1'b1, lat, bok);
    chk("b2b busy during second", 32'(bok), 32'h1);
    chk("b2b second latency", 32'(lat), 32'(TOT));
    chk("b2b second valid", 32'(valid_o), 32'h1);
    chk("b2b second payload", 32'(payload_o), 32'h0F);
    chk("b2b drop unchanged", 32'(drop_cnt_o), 32'd15);
    drive(1'b0, 1'b0, 1'b1);
    tick();
    chk("b2b valid after transfer", 32'(valid_o), 32'h0);

    // Reset after 4 payload bits of 8'hB2.
    send_sync(1'b1);
    drive(1'b1, 1'b1, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b1); tick();
    drive(1'b1, 1'b0, 1'b1); tick();
    drive(1'b1, 1'b0, 1'b1); tick();
    chk("pre-reset busy", 32'(busy_o), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("midcap reset payload", 32'(payload_o), 32'h0);
    chk("midcap reset valid", 32'(valid_o), 32'h0);
    chk("midcap reset busy", 32'(busy_o), 32'h0);
    chk("midcap reset drop", 32'(drop_cnt_o), 32'h0);
    chk("midcap reset perr", 32'(parity_err_o), 32'h0);
    drive(1'b0, 1'b0, 1'b1);
    tick();
    reset_n = 1'b1;
    tick();
    send_sync(1'b1);
    capture_bits(8'hC3, 1'b0, 1'b1, lat, bok);
    chk("post-reset latency", 32'(lat), 32'(TOT));
    chk("post-reset payload", 32'(payload_o), 32'hC3);
    chk("post-reset drop", 32'(drop_cnt_o), 32'h0);
    drive(1'b0, 1'b0, 1'b1);
    tick();
    chk("post-reset valid after transfer", 32'(valid_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
